// File: rtl/spi_slave_if.sv
// SPI pad-side signals between an SPI master and the spi_slave byte transceiver.
interface spi_slave_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_slave.sv
// SPI slave byte transceiver: oversamples sclk/ss_n/mosi with clk, all four cpol/cpha modes,
// MSB first, back-to-back bytes while ss_n stays low.
module spi_slave (
  input  logic       clk,
  input  logic       reset_n,
  spi_slave_if.slave spi,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       ld_tick,
  output logic       frame_err_tick,
  output logic       busy
);
  typedef enum logic {st_idle = 1'b0, st_active = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic       sclk_meta, sclk_s, sclk_d;
  logic       ss_meta, ss_s, ss_d;
  logic       mosi_meta, mosi_s;
  logic [7:0] si_reg, si_next;
  logic [7:0] so_reg, so_next;
  logic [7:0] dout_reg, dout_next;
  logic [2:0] n_reg, n_next;
  logic       nclk, nclk_d, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, ss_fall;

  // Two-flop synchronizers on the asynchronous pins plus one-cycle delayed copies for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_d    <= 1'b0;
      ss_meta   <= 1'b0;
      ss_s      <= 1'b0;
      ss_d      <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sclk_meta <= spi.sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      ss_meta   <= spi.ss_n;
      ss_s      <= ss_meta;
      ss_d      <= ss_s;
      mosi_meta <= spi.mosi;
      mosi_s    <= mosi_meta;
    end
  end

  // Normalizing by cpol makes "leading" mean the first edge away from the idle level.
  assign nclk        = sclk_s ^ cpol;
  assign nclk_d      = sclk_d ^ cpol;
  assign lead_edge   = nclk & ~nclk_d;
  assign trail_edge  = ~nclk & nclk_d;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign ss_fall     = ss_d & ~ss_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= st_idle;
      si_reg    <= 8'h00;
      so_reg    <= 8'h00;
      dout_reg  <= 8'h00;
      n_reg     <= 3'd0;
    end else begin
      state_reg <= state_next;
      si_reg    <= si_next;
      so_reg    <= so_next;
      dout_reg  <= dout_next;
      n_reg     <= n_next;
    end
  end

  // Next-state, datapath updates and event pulses; a deselect wins over a same-cycle sclk edge.
  always_comb begin
    state_next     = state_reg;
    si_next        = si_reg;
    so_next        = so_reg;
    dout_next      = dout_reg;
    n_next         = n_reg;
    rx_done_tick   = 1'b0;
    ld_tick        = 1'b0;
    frame_err_tick = 1'b0;
    case (state_reg)
      st_idle: begin
        if (ss_fall) begin
          so_next    = din;
          n_next     = 3'd0;
          ld_tick    = 1'b1;
          state_next = st_active;
        end else begin
          state_next = st_idle;
        end
      end
      st_active: begin
        if (ss_s) begin
          state_next     = st_idle;
          frame_err_tick = (n_reg != 3'd0);
        end else if (sample_edge) begin
          si_next = {si_reg[6:0], mosi_s};
          n_next  = n_reg + 3'd1;
          if (n_reg == 3'd7) begin
            dout_next    = {si_reg[6:0], mosi_s};
            rx_done_tick = 1'b1;
            so_next      = din;
            ld_tick      = 1'b1;
          end else begin
            dout_next = dout_reg;
          end
        end else if (shift_edge && (n_reg != 3'd0)) begin
          // At n_reg==0 the freshly loaded bit 7 is held for the whole first bit.
          so_next = {so_reg[6:0], 1'b0};
        end else begin
          so_next = so_reg;
        end
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  assign busy        = (state_reg == st_active);
  assign spi.miso_oe = busy;
  assign spi.miso    = busy & so_reg[7];
  assign dout        = dout_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized self-checking bench for spi_slave: a bit-level SPI master plus a transaction-level model.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       rx_done_tick, ld_tick, frame_err_tick, busy;

  spi_slave_if spi_bus ();

  spi_slave dut (
    .clk(clk), .reset_n(reset_n), .spi(spi_bus), .cpol(cpol), .cpha(cpha), .din(din),
    .dout(dout), .rx_done_tick(rx_done_tick), .ld_tick(ld_tick),
    .frame_err_tick(frame_err_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dut_ld = 0, dut_rx = 0, dut_err = 0;
  int prev_rx_cyc = 0, last_rx_cyc = 0;
  logic [7:0] model_dout = 8'h00;
  bit         rx_pend = 1'b0;
  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];
  logic [7:0] loaded_q [$];
  logic [7:0] sdin_q [$];
  logic [7:0] exp_rx_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: dout against the queue of completed master bytes, plus output invariants.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_dout = 8'h00;
      rx_pend    = 1'b0;
    end else begin
      if (rx_pend) begin
        n_checks++;
        if (exp_rx_q.size() == 0) begin
          n_errors++;
          $display("FAIL rx_unexpected: got rx_done_tick=1 expected no completed byte (cycle %0d)", cyc);
        end else begin
          model_dout = exp_rx_q.pop_front();
        end
        rx_pend = 1'b0;
      end
      check("dout", dout, model_dout);
      check("busy_vs_oe", busy, spi_bus.miso_oe);
      if (!spi_bus.miso_oe) check("miso_idle", spi_bus.miso, 1'b0);
      if (rx_done_tick) begin
        check("ld_with_rx", ld_tick, 1'b1);
        rx_pend     = 1'b1;
        dut_rx++;
        prev_rx_cyc = last_rx_cyc;
        last_rx_cyc = cyc;
      end
      if (ld_tick) dut_ld++;
      if (frame_err_tick) dut_err++;
    end
  end

  // Slave-side feeder: records each captured din and presents the next byte after the capture edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && ld_tick) begin
        loaded_q.push_back(din);
        @(posedge clk);
        #1;
        if (sdin_q.size() != 0) din = sdin_q.pop_front();
        else din = 8'($urandom);
      end
    end
  end

  // kind: 0 full frame, 1 abort after cut bits, 2 deselect colliding with the sample edge after cut bits,
  // 3 reset after cut bits.
  task automatic frame(input logic [1:0] mode, input int half, input int nbytes,
                       input int kind, input int cut);
    int nbits, full, ld0, rx0, err0, bi, bpos;
    logic [7:0] sh;
    sh   = 8'h00;
    cpol = mode[1];
    cpha = mode[0];
    spi_bus.sclk = mode[1];
    spi_bus.ss_n = 1'b1;
    wait_cyc(6);
    ld0 = dut_ld; rx0 = dut_rx; err0 = dut_err;
    nbits = (kind == 0) ? nbytes * 8 : cut;
    full  = nbits / 8;
    if (!cpha) spi_bus.mosi = m_tx[0][7];
    spi_bus.ss_n = 1'b0;
    wait_cyc(half);
    for (int b = 0; b < nbits; b++) begin
      bi   = b / 8;
      bpos = 7 - (b % 8);
      if ((b % 8) == 7) exp_rx_q.push_back(m_tx[bi]);
      if (!cpha) begin
        spi_bus.sclk = ~cpol;
        sh = {sh[6:0], spi_bus.miso};
        wait_cyc(half);
        spi_bus.sclk = cpol;
        if (b + 1 < nbits) spi_bus.mosi = m_tx[(b + 1) / 8][7 - ((b + 1) % 8)];
        wait_cyc(half);
      end else begin
        spi_bus.sclk = ~cpol;
        spi_bus.mosi = m_tx[bi][bpos];
        wait_cyc(half);
        spi_bus.sclk = cpol;
        sh = {sh[6:0], spi_bus.miso};
        wait_cyc(half);
      end
      if ((b % 8) == 7) begin
        m_rx[bi] = sh;
        n_checks++;
        if (loaded_q.size() == 0) begin
          n_errors++;
          $display("FAIL master_rx: got %0h expected a loaded slave byte, none captured", sh);
        end else begin
          check("master_rx", sh, loaded_q.pop_front());
        end
      end
    end
    if (kind == 2) begin
      if (!cpha) begin
        spi_bus.sclk = ~cpol;
        spi_bus.ss_n = 1'b1;
      end else begin
        spi_bus.sclk = ~cpol;
        spi_bus.mosi = m_tx[full][0];
        wait_cyc(half);
        spi_bus.sclk = cpol;
        spi_bus.ss_n = 1'b1;
      end
    end else if (kind == 3) begin
      reset_n = 1'b0;
      #1;
      check("rst_mid_dout", dout, 8'h00);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_miso", spi_bus.miso, 1'b0);
      check("rst_mid_oe", spi_bus.miso_oe, 1'b0);
      check("rst_mid_ticks", {rx_done_tick, ld_tick, frame_err_tick}, 3'b000);
      spi_bus.ss_n = 1'b1;
      spi_bus.sclk = cpol;
      exp_rx_q.delete();
      wait_cyc(3);
      @(negedge clk);
      reset_n = 1'b1;
    end else begin
      spi_bus.ss_n = 1'b1;
    end
    wait_cyc(8);
    spi_bus.sclk = cpol;
    wait_cyc(4);
    if (kind != 3) begin
      check("ld_count", dut_ld - ld0, full + 1);
      check("rx_count", dut_rx - rx0, full);
      check("err_count", dut_err - err0, (kind == 0) ? 0 : 1);
      check("busy_after", busy, 1'b0);
    end
    check("rx_outstanding", exp_rx_q.size(), 0);
    loaded_q.delete();
    sdin_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] mode;
    int nb, kind, cut;
    spi_bus.sclk = 1'b0;
    spi_bus.ss_n = 1'b1;
    spi_bus.mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_miso", spi_bus.miso, 1'b0);
    check("rst_oe", spi_bus.miso_oe, 1'b0);
    check("rst_ticks", {rx_done_tick, ld_tick, frame_err_tick}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(4);

    // Mode 0 exchange, dvsr=7 (half period 8).
    m_tx[0] = 8'hA5; din = 8'h3C;
    frame(2'd0, 8, 1, 0, 0);
    check("m0_slave_dout", dout, 8'hA5);
    check("m0_master_rx", m_rx[0], 8'h3C);

    // Mode 3 exchange.
    m_tx[0] = 8'h81; din = 8'h7E;
    frame(2'd3, 8, 1, 0, 0);
    check("m3_slave_dout", dout, 8'h81);
    check("m3_master_rx", m_rx[0], 8'h7E);

    // Back-to-back bytes in mode 1; din changes after the first load.
    m_tx[0] = 8'h12; m_tx[1] = 8'h34; din = 8'hC3; sdin_q.push_back(8'h5A);
    frame(2'd1, 8, 2, 0, 0);
    check("b2b_slave_dout", dout, 8'h34);
    check("b2b_master_rx0", m_rx[0], 8'hC3);
    check("b2b_master_rx1", m_rx[1], 8'h5A);
    check("b2b_rx_spacing", last_rx_cyc - prev_rx_cyc, 128);

    // Abort after 3 bits in mode 2, then a good F0 frame.
    m_tx[0] = 8'hE7; din = 8'h99;
    frame(2'd2, 7, 1, 1, 3);
    check("abort_dout_held", dout, 8'h34);
    m_tx[0] = 8'hF0; din = 8'h0F;
    frame(2'd2, 7, 1, 0, 0);
    check("after_abort_dout", dout, 8'hF0);
    check("after_abort_master_rx", m_rx[0], 8'h0F);

    // Reset after 5 bits, then a full 5A exchange.
    m_tx[0] = 8'hC6; din = 8'h11;
    frame(2'd0, 6, 1, 3, 5);
    check("post_reset_dout", dout, 8'h00);
    m_tx[0] = 8'h5A; din = 8'h5A;
    frame(2'd0, 6, 1, 0, 0);
    check("reset_recover_dout", dout, 8'h5A);
    check("reset_recover_master_rx", m_rx[0], 8'h5A);

    // Deselect landing on the 8th sample edge.
    m_tx[0] = 8'h3D; din = 8'h42;
    frame(2'd0, 6, 1, 2, 7);
    check("collide_dout_held", dout, 8'h5A);

    // Randomized frames across all modes and endings.
    for (int f = 0; f < 30; f++) begin
      mode = 2'($urandom_range(0, 3));
      nb   = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) m_tx[i] = 8'($urandom);
      din  = 8'($urandom);
      for (int i = 0; i < 3; i++) sdin_q.push_back(8'($urandom));
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        kind = 0; cut = 0;
      end else if (kind < 9) begin
        kind = 1; cut = $urandom_range(0, nb - 1) * 8 + $urandom_range(1, 7);
      end else begin
        kind = 2; cut = $urandom_range(0, nb - 1) * 8 + 7;
      end
      frame(mode, $urandom_range(6, 9), nb, kind, cut);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
